// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 64x64 multiplier: FSM state
// encoding, datapath widths, per-step shift amounts and an alignment helper.
package mult_pkg;

  localparam int HALF_W = 32;
  localparam int PROD_W = 128;

  // Left shift applied to each partial product before accumulation
  localparam logic [6:0] SH_PP0 = 7'd0;   // a_lo * b_lo
  localparam logic [6:0] SH_PP1 = 7'd32;  // a_lo * b_hi
  localparam logic [6:0] SH_PP2 = 7'd32;  // a_hi * b_lo
  localparam logic [6:0] SH_PP3 = 7'd64;  // a_hi * b_hi

  // DRAIN is only entered when the partial-product register is built in
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PP0   = 3'd1,
    PP1   = 3'd2,
    PP2   = 3'd3,
    PP3   = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Zero-extend a 64-bit partial product to the product width and shift it
  function automatic logic [PROD_W-1:0] align_pp(input logic [2*HALF_W-1:0] pp,
                                                 input logic [6:0]          sh);
    return {{(PROD_W-2*HALF_W){1'b0}}, pp} << sh;
  endfunction

endpackage

// File: rtl/mult_32bit.sv
// Combinational 32x32 -> 64-bit unsigned Vedic (urdhva-tiryagbhyam) core:
// vertical products of the 16-bit halves plus the crosswise sum.
module mult_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] c
);

  logic [31:0] w_ll;
  logic [31:0] w_lh;
  logic [31:0] w_hl;
  logic [31:0] w_hh;
  logic [32:0] w_cross;

  assign w_ll    = a[15:0]  * b[15:0];
  assign w_lh    = a[15:0]  * b[31:16];
  assign w_hl    = a[31:16] * b[15:0];
  assign w_hh    = a[31:16] * b[31:16];
  assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};

  // Vertical terms at weights 0 and 32, crosswise term at weight 16
  assign c = {32'b0, w_ll} + {15'b0, w_cross, 16'b0} + {w_hh, 32'b0};

endmodule

// File: rtl/mult_64bit_seq.sv
// Sequential 64x64 -> 128-bit unsigned multiplier. One shared mult_32bit
// core is stepped over the four half-word partial products (PP0..PP3), which
// are accumulated into a 128-bit register that drives result.
// Handshake: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; the result transfers on an edge where out_valid and
// out_ready are both high. result is held while out_valid waits for out_ready.
// Build option: define MULT_PP_REG_EN to register the core output before the
// adder (adds a DRAIN state and one cycle of latency, same results).
module mult_64bit_seq
  import mult_pkg::*;
#(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] result,
  output logic              busy,
  output state_t            o_dbg_state
);

  state_t                r_state;
  state_t                w_next_state;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic [PROD_W-1:0]     r_acc;
  logic [HALF_W-1:0]     w_core_a;
  logic [HALF_W-1:0]     w_core_b;
  logic [2*HALF_W-1:0]   w_pp;
  logic [6:0]            w_shift;
  logic                  w_pp_step;
  logic                  w_accept;
  logic [PROD_W-1:0]     w_acc_add;

  // Accept decision uses the state register only; rst overrides it anyway
  assign w_accept = in_valid && (r_state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: fixed walk through the partial products
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = PP0;
      PP0:     w_next_state = PP1;
      PP1:     w_next_state = PP2;
      PP2:     w_next_state = PP3;
`ifdef MULT_PP_REG_EN
      PP3:     w_next_state = DRAIN;
      DRAIN:   w_next_state = DONE;
`else
      PP3:     w_next_state = DONE;
`endif
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    in_ready    = (r_state == IDLE) && !rst;
    busy        = (r_state != IDLE);
    out_valid   = (r_state == DONE);
    result      = r_acc;
    o_dbg_state = r_state;
  end

  // Operand capture on the accept edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Core operand-half mux and shift selection per partial-product state
  always_comb begin
    w_core_a  = '0;
    w_core_b  = '0;
    w_shift   = SH_PP0;
    w_pp_step = 1'b0;
    case (r_state)
      PP0: begin
        w_core_a = r_a[HALF_W-1:0];   w_core_b = r_b[HALF_W-1:0];
        w_shift  = SH_PP0;            w_pp_step = 1'b1;
      end
      PP1: begin
        w_core_a = r_a[HALF_W-1:0];   w_core_b = r_b[W-1:HALF_W];
        w_shift  = SH_PP1;            w_pp_step = 1'b1;
      end
      PP2: begin
        w_core_a = r_a[W-1:HALF_W];   w_core_b = r_b[HALF_W-1:0];
        w_shift  = SH_PP2;            w_pp_step = 1'b1;
      end
      PP3: begin
        w_core_a = r_a[W-1:HALF_W];   w_core_b = r_b[W-1:HALF_W];
        w_shift  = SH_PP3;            w_pp_step = 1'b1;
      end
      default: ;
    endcase
  end

  mult_32bit u_core (
    .a (w_core_a),
    .b (w_core_b),
    .c (w_pp)
  );

`ifdef MULT_PP_REG_EN
  logic [2*HALF_W-1:0] r_pp;
  logic [6:0]          r_pp_shift;
  logic                r_pp_vld;

  // Pipeline register between the core and the adder; step k adds in step k+1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pp       <= '0;
      r_pp_shift <= '0;
      r_pp_vld   <= 1'b0;
    end else begin
      r_pp       <= w_pp;
      r_pp_shift <= w_shift;
      r_pp_vld   <= w_pp_step;
    end
  end

  assign w_acc_add = r_pp_vld ? align_pp(r_pp, r_pp_shift) : '0;
`else
  assign w_acc_add = w_pp_step ? align_pp(w_pp, w_shift) : '0;
`endif

  // Accumulator: cleared on reset and on accept, otherwise adds the step term
  always_ff @(posedge clk) begin
    if (rst)           r_acc <= '0;
    else if (w_accept) r_acc <= '0;
    else               r_acc <= r_acc + w_acc_add;
  end

endmodule

// File: tb/tb_mult_64bit_seq.sv
// Directed bench for mult_64bit_seq. Build with or without MULT_PP_REG_EN;
// the expected latency follows the same macro.
module tb_mult_64bit_seq;
  import mult_pkg::*;

`ifdef MULT_PP_REG_EN
  localparam int EXP_LAT = 6;
`else
  localparam int EXP_LAT = 5;
`endif
  localparam int EXP_GAP = EXP_LAT + 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         busy;
  state_t       dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  mult_64bit_seq #(.W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Offer an operand pair at a negedge; returns 1ns after the accept edge
  // with the bus scrambled to show the operands were registered.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_v;
  endtask

  // After the accept edge, count cycles until out_valid is seen (bounded)
  task automatic wait_out(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 1;
    while (!seen && lat <= 20) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL out_valid_timeout: no out_valid within 20 cycles, expected by %0d", EXP_LAT);
    end
  endtask

  // Hand the result to the consumer for one edge
  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (result !== 128'd0) begin n_err++; $display("FAIL rst_result: got %h expected 0", result); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_zero();
    int lat;
    start_op(64'd0, 64'd0);
    wait_out(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", lat, EXP_LAT); end
    n_vec++; if (result !== 128'd0) begin n_err++; $display("FAIL zero_result: got %h expected 0", result); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b expected 1", busy); end
    finish_op();
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_idle_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_vectors();
    logic [63:0]  va [5];
    logic [63:0]  vb [5];
    logic [127:0] vp [5];
    int lat;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    vp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    va[1] = 64'h1_0000_0000;         vb[1] = 64'h1_0000_0000;
    vp[1] = 128'h1_0000_0000_0000_0000;
    va[2] = 64'h1_0000_0001;         vb[2] = 64'h1_0000_0001;
    vp[2] = 128'h1_0000_0002_0000_0001;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'd2;
    vp[3] = 128'h1_0000_0000_0000_0000;
    va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'd2;
    vp[4] = 128'h1_FFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vp[i]);
      start_op(va[i], vb[i]);
      wait_out(lat);
      n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, EXP_LAT); end
      n_vec++;
      if (result !== exp_q[0]) begin n_err++; $display("FAIL vec%0d_result: got %h expected %h", i, result, exp_q[0]); end
      void'(exp_q.pop_front());
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_r;
    int lat;
    exp_r = 128'h0369_D036_9D03_69CD;
    start_op(64'h0123_4567_89AB_CDEF, 64'd3);
    wait_out(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", lat, EXP_LAT); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid); end
      n_vec++; if (result !== exp_r) begin n_err++; $display("FAIL bp_hold_result%0d: got %h expected %h", i, result, exp_r); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, in_ready); end
      in_valid = (i == 1 || i == 2);
      a = 64'd9; b = 64'd9;
      @(negedge clk);
    end
    n_vec++; if (result !== exp_r) begin n_err++; $display("FAIL bp_after_pulse: got %h expected %h", result, exp_r); end
    finish_op();
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL bp_state_after: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    n_vec++; if (dbg_state !== PP2) begin n_err++; $display("FAIL rm_in_pp2: got %0d expected %0d", dbg_state, PP2); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_vec++; if (result !== 128'd0) begin n_err++; $display("FAIL rm_result: got %h expected 0", result); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_in_rst: got %b expected 0", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_release: got %b expected 1", in_ready); end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    n_vec++; if (saw_valid) begin n_err++; $display("FAIL rm_no_valid: got out_valid pulse expected none"); end
    start_op(64'd5, 64'd7);
    wait_out(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL rm_next_latency: got %0d expected %0d", lat, EXP_LAT); end
    n_vec++; if (result !== 128'd35) begin n_err++; $display("FAIL rm_next_result: got %h expected 23", result); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [63:0]  ta [3];
    logic [63:0]  tbv[3];
    logic [127:0] tp [3];
    int acc_cyc[3];
    int nacc, nres, cyc;
    bit take;
    ta[0] = 64'd3;                    tbv[0] = 64'd5;       tp[0] = 128'd15;
    ta[1] = 64'hFFFF_FFFF;            tbv[1] = 64'hFFFF_FFFF; tp[1] = 128'hFFFF_FFFE_0000_0001;
    ta[2] = 64'h0123_4567_89AB_CDEF;  tbv[2] = 64'd3;       tp[2] = 128'h0369_D036_9D03_69CD;
    nacc = 0; nres = 0; cyc = 0;
    @(negedge clk);
    a = ta[0]; b = tbv[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (cyc < 40 && nres < 3) begin
      take = 1'b0;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected: got result %h expected none", result);
        end else begin
          if (result !== exp_q[0]) begin n_err++; $display("FAIL b2b_result%0d: got %h expected %h", nres, result, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        nres++;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1 && nacc < 3) begin
        exp_q.push_back(tp[nacc]);
        acc_cyc[nacc] = cyc;
        nacc++;
        take = 1'b1;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (nacc == 3) in_valid = 1'b0;
        else begin a = ta[nacc]; b = tbv[nacc]; end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (nres != 3) begin n_err++; $display("FAIL b2b_count: got %0d results expected 3", nres); end
    if (nacc == 3) begin
      n_vec++; if (acc_cyc[1] - acc_cyc[0] != EXP_GAP) begin n_err++; $display("FAIL b2b_gap01: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], EXP_GAP); end
      n_vec++; if (acc_cyc[2] - acc_cyc[1] != EXP_GAP) begin n_err++; $display("FAIL b2b_gap12: got %0d expected %0d", acc_cyc[2] - acc_cyc[1], EXP_GAP); end
    end else begin
      n_vec++; n_err++; $display("FAIL b2b_accepts: got %0d expected 3", nacc);
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
